// File: rtl/mips_alu_mc_if.sv
// Start/done handshake bundle between the EX-stage control and the multi-cycle ALU.
interface mips_alu_mc_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [3:0]       ALUctl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUOut;
    logic [WIDTH-1:0] HiOut;
    logic             Zero;
    logic             Overflow;

    modport master (
        output start, ALUctl, A, B,
        input  busy, done, ALUOut, HiOut, Zero, Overflow
    );

    modport slave (
        input  start, ALUctl, A, B,
        output busy, done, ALUOut, HiOut, Zero, Overflow
    );
endinterface

// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith ops plus iterative unsigned
// shift-add multiply and restoring divide, with a HI result register.
module mips_alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clock,
    input logic           reset_n,
    mips_alu_mc_if.slave  bus
);
    localparam int unsigned CNTW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MULU = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] hi_out_q;
    logic             zero_q;
    logic             ovf_q;

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic [WIDTH:0]   mul_acc_c;
    logic [WIDTH:0]   div_sh_c;
    logic [WIDTH-1:0] div_sub_c;
    logic             div_ge_c;

    // Single-cycle result for the operands currently on the bus
    always_comb begin
        sum_c  = bus.A + bus.B;
        diff_c = bus.A - bus.B;
        res_c  = '0;
        ovf_c  = 1'b0;
        case (bus.ALUctl)
            OP_AND:  res_c = bus.A & bus.B;
            OP_OR:   res_c = bus.A | bus.B;
            OP_ADD: begin
                res_c = sum_c;
                ovf_c = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_c[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = diff_c;
                ovf_c = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_c[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_NOR:  res_c = ~(bus.A | bus.B);
            OP_DIVU: res_c = '1;
            default: res_c = '0;
        endcase
    end

    // One iteration step: hi_r/lo_r hold {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_acc_c = lo_r[0] ? ({1'b0, hi_r} + {1'b0, opnd}) : {1'b0, hi_r};
        div_sh_c  = {hi_r, lo_r[WIDTH-1]};
        div_ge_c  = div_sh_c >= {1'b0, opnd};
        div_sub_c = WIDTH'(div_sh_c - {1'b0, opnd});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            opnd      <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_out_q <= '0;
            hi_out_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.ALUctl == OP_MULU) begin
                            state  <= MUL;
                            busy_q <= 1'b1;
                            count  <= CNTW'(WIDTH);
                            opnd   <= bus.A;
                            lo_r   <= bus.B;
                            hi_r   <= '0;
                        end else if (bus.ALUctl == OP_DIVU && bus.B != '0) begin
                            state  <= DIV;
                            busy_q <= 1'b1;
                            count  <= CNTW'(WIDTH);
                            opnd   <= bus.B;
                            lo_r   <= bus.A;
                            hi_r   <= '0;
                        end else begin
                            done_q    <= 1'b1;
                            alu_out_q <= res_c;
                            hi_out_q  <= (bus.ALUctl == OP_DIVU) ? bus.A : '0;
                            zero_q    <= (res_c == '0);
                            ovf_q     <= ovf_c;
                        end
                    end
                end
                MUL, DIV: begin
                    if (count != '0) begin
                        count <= count - CNTW'(1);
                        if (state == MUL) begin
                            hi_r <= mul_acc_c[WIDTH:1];
                            lo_r <= {mul_acc_c[0], lo_r[WIDTH-1:1]};
                        end else begin
                            hi_r <= div_ge_c ? div_sub_c : div_sh_c[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], div_ge_c};
                        end
                    end else begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        alu_out_q <= lo_r;
                        hi_out_q  <= hi_r;
                        zero_q    <= (lo_r == '0);
                        ovf_q     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ALUOut   = alu_out_q;
    assign bus.HiOut    = hi_out_q;
    assign bus.Zero     = zero_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_mips_alu_mc.sv
// Scoreboard bench for mips_alu_mc: 32-bit and 8-bit instances against an arithmetic reference model.
module tb_mips_alu_mc;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    mips_alu_mc_if #(.WIDTH(32)) bus32();
    mips_alu_mc_if #(.WIDTH(8))  bus8();

    mips_alu_mc #(.WIDTH(32)) u32 (.clock(clock), .reset_n(reset_n), .bus(bus32));
    mips_alu_mc #(.WIDTH(8))  u8  (.clock(clock), .reset_n(reset_n), .bus(bus8));

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        v;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [3:0] ctl, input logic [31:0] a_in, input logic [31:0] b_in, input int w);
        logic [63:0] mask, a, b, r, p;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        a = {32'b0, a_in} & mask;
        b = {32'b0, b_in} & mask;
        r = '0;
        e.hi = '0;
        e.v = 1'b0;
        case (ctl)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                r = (a + b) & mask;
                e.v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            4'd6: begin
                r = (a - b) & mask;
                e.v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            4'd7:  r = (a[w-1] != b[w-1]) ? {63'b0, a[w-1]} : {63'b0, (a < b)};
            4'd12: r = ~(a | b) & mask;
            4'd3: begin
                p = a * b;
                r = p & mask;
                e.hi = 32'((p >> w) & mask);
            end
            4'd4: begin
                if (b == 64'd0) begin
                    r = mask;
                    e.hi = 32'(a);
                end else begin
                    r = a / b;
                    e.hi = 32'(a % b);
                end
            end
            default: r = '0;
        endcase
        e.lo = 32'(r);
        e.z  = (r == 64'd0);
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] ctl, input logic [31:0] b, input int w);
        return (ctl == 4'd3 || (ctl == 4'd4 && b != 32'd0)) ? w + 1 : 0;
    endfunction

    task automatic issue32(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b, input bit hold);
        @(negedge clock);
        bus32.start = 1'b1; bus32.ALUctl = ctl; bus32.A = a; bus32.B = b;
        q32.push_back(model(ctl, a, b, 32));
        @(posedge clock); #1;
        if (!hold) bus32.start = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        bus8.start = 1'b1; bus8.ALUctl = ctl; bus8.A = a; bus8.B = b;
        q8.push_back(model(ctl, {24'b0, a}, {24'b0, b}, 8));
        @(posedge clock); #1;
        bus8.start = 1'b0;
    endtask

    // Negedges seen after the start edge before done; -1 if it never comes
    task automatic wait32(output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus32.done === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic wait8(output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus8.done === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({bus32.busy, bus32.done, bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b lo=%h hi=%h z=%b v=%b, want 0 0 0 0 1 0",
                     bus32.busy, bus32.done, bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        logic [3:0]  c[12] = '{4'd6, 4'd6, 4'd2, 4'd6, 4'd7, 4'd0, 4'd1, 4'd12, 4'd6, 4'd7, 4'd5, 4'd2};
        logic [31:0] a[12] = '{32'hD, 32'hF, 32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hF0, 32'hF0, 32'h0F0F_0000,
                               32'h8000_0000, 32'd3, 32'h55, 32'hFFFF_FFFF};
        logic [31:0] b[12] = '{32'h6, 32'h2, 32'h1, 32'd5, 32'd1, 32'h3C, 32'h3C, 32'h0000_00F0,
                               32'd1, 32'hFFFF_FFFE, 32'h66, 32'h1};
        logic [3:0]  ops[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        logic [3:0]  ctl;
        logic [31:0] av, bv;
        exp_t e;
        int lat;
        for (int i = 0; i < 18; i++) begin
            if (i < 12) begin ctl = c[i]; av = a[i]; bv = b[i]; end
            else begin ctl = ops[$urandom_range(5)]; av = $urandom(); bv = $urandom(); end
            issue32(ctl, av, bv, 1'b0);
            wait32(lat);
            checks++;
            if (lat !== 0) begin errors++; $display("FAIL single_lat[%0d]: got %0d want 0", i, lat); end
            e = q32.pop_front();
            checks++;
            if ({bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow} !== {e.lo, e.hi, e.z, e.v}) begin
                errors++;
                $display("FAIL single[%0d] ctl=%0d: got lo=%h hi=%h z=%b v=%b want lo=%h hi=%h z=%b v=%b", i, ctl,
                         bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow, e.lo, e.hi, e.z, e.v);
            end
            @(negedge clock);
            checks++;
            if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
                errors++; $display("FAIL single_pulse[%0d]: done=%b busy=%b want 0 0", i, bus32.done, bus32.busy);
            end
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]  c[9] = '{4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3, 4'd4};
        logic [31:0] a[9] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd100, 32'h1234, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] b[9] = '{32'h2, 32'h123, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd9, 32'd1, 32'd0, 32'd0};
        logic [31:0] av, bv;
        exp_t e;
        int lat, want, pre;
        for (int i = 0; i < 9; i++) begin
            av = (i >= 7) ? $urandom() : a[i];
            bv = (i >= 7) ? $urandom() | 32'd1 : b[i];
            issue32(c[i], av, bv, 1'b0);
            want = exp_lat(c[i], bv, 32);
            pre = 0;
            if (want != 0) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock);
                    checks++;
                    if (bus32.busy !== 1'b1 || bus32.done !== 1'b0) begin
                        errors++; $display("FAIL muldiv_busy[%0d]: busy=%b done=%b want 1 0", i, bus32.busy, bus32.done);
                    end
                end
                pre = 5;
                if (i == 0) begin
                    bus32.start = 1'b1; bus32.ALUctl = 4'd2; bus32.A = 32'd1; bus32.B = 32'd1;
                    @(posedge clock); #1;
                    bus32.start = 1'b0;
                end
            end
            wait32(lat);
            checks++;
            if (pre + lat !== want) begin errors++; $display("FAIL muldiv_lat[%0d]: got %0d want %0d", i, pre + lat, want); end
            e = q32.pop_front();
            checks++;
            if ({bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow} !== {e.lo, e.hi, e.z, e.v}) begin
                errors++;
                $display("FAIL muldiv[%0d] ctl=%0d: got lo=%h hi=%h z=%b v=%b want lo=%h hi=%h z=%b v=%b", i, c[i],
                         bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow, e.lo, e.hi, e.z, e.v);
            end
            @(negedge clock);
            checks++;
            if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
                errors++; $display("FAIL muldiv_idle[%0d]: done=%b busy=%b want 0 0", i, bus32.done, bus32.busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  c[4] = '{4'd2, 4'd0, 4'd12, 4'd6};
        logic [31:0] a[4] = '{32'd3, 32'hF0F0, 32'h1, 32'd10};
        logic [31:0] b[4] = '{32'd4, 32'hFF00, 32'h2, 32'd3};
        exp_t e;
        int lat;
        issue32(4'd3, 32'h1234_5678, 32'h9ABC, 1'b1);
        bus32.ALUctl = c[0]; bus32.A = a[0]; bus32.B = b[0];
        wait32(lat);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL b2b_lat: got %0d want 33", lat); end
        for (int i = 0; i < 5; i++) begin
            e = q32.pop_front();
            checks++;
            if (bus32.done !== 1'b1 || {bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow} !== {e.lo, e.hi, e.z, e.v}) begin
                errors++;
                $display("FAIL b2b[%0d]: got done=%b lo=%h hi=%h z=%b v=%b want done=1 lo=%h hi=%h z=%b v=%b", i, bus32.done,
                         bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow, e.lo, e.hi, e.z, e.v);
            end
            if (i < 4) begin
                bus32.ALUctl = c[i]; bus32.A = a[i]; bus32.B = b[i];
                q32.push_back(model(c[i], a[i], b[i], 32));
                @(negedge clock);
            end
        end
        bus32.start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus32.done !== 1'b0) begin errors++; $display("FAIL b2b_end: done=%b want 0", bus32.done); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int lat;
        issue32(4'd3, 32'hFFFF_FFFF, 32'd3, 1'b0);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus32.busy, bus32.done, bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b lo=%h hi=%h z=%b v=%b, want 0 0 0 0 1 0",
                     bus32.busy, bus32.done, bus32.ALUOut, bus32.HiOut, bus32.Zero, bus32.Overflow);
        end
        q32.delete();
        @(negedge clock);
        reset_n = 1'b1;
        issue32(4'd0, 32'hF0, 32'h3C, 1'b0);
        wait32(lat);
        e = q32.pop_front();
        checks++;
        if (lat !== 0 || {bus32.ALUOut, bus32.HiOut, bus32.Zero} !== {e.lo, e.hi, e.z}) begin
            errors++;
            $display("FAIL after_reset: lat=%0d lo=%h hi=%h z=%b want lat=0 lo=%h hi=%h z=%b",
                     lat, bus32.ALUOut, bus32.HiOut, bus32.Zero, e.lo, e.hi, e.z);
        end
    endtask

    task automatic test_width8;
        logic [3:0] c[7] = '{4'd3, 4'd15, 4'd2, 4'd4, 4'd4, 4'd6, 4'd3};
        logic [7:0] a[7] = '{8'hFF, 8'h12, 8'h7F, 8'd200, 8'h5A, 8'h80, 8'h0};
        logic [7:0] b[7] = '{8'hFF, 8'h34, 8'h01, 8'd7, 8'h0, 8'h01, 8'h0};
        logic [7:0] av, bv;
        exp_t e;
        int lat, want;
        for (int i = 0; i < 9; i++) begin
            if (i < 7) begin av = a[i]; bv = b[i]; end
            else begin av = 8'($urandom()); bv = 8'($urandom()); end
            issue8((i < 7) ? c[i] : 4'(3 + (i - 7)), av, bv);
            want = exp_lat((i < 7) ? c[i] : 4'(3 + (i - 7)), {24'b0, bv}, 8);
            wait8(lat);
            checks++;
            if (lat !== want) begin errors++; $display("FAIL w8_lat[%0d]: got %0d want %0d", i, lat, want); end
            e = q8.pop_front();
            checks++;
            if ({24'b0, bus8.ALUOut, 24'b0, bus8.HiOut, bus8.Zero, bus8.Overflow} !== {e.lo, e.hi, e.z, e.v}) begin
                errors++;
                $display("FAIL w8[%0d]: got lo=%h hi=%h z=%b v=%b want lo=%h hi=%h z=%b v=%b", i,
                         bus8.ALUOut, bus8.HiOut, bus8.Zero, bus8.Overflow, e.lo, e.hi, e.z, e.v);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        bus32.start = 1'b0; bus32.ALUctl = 4'd0; bus32.A = '0; bus32.B = '0;
        bus8.start  = 1'b0; bus8.ALUctl  = 4'd0; bus8.A  = '0; bus8.B  = '0;
        test_reset();
        test_single();
        test_muldiv();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
